ifetch_pc_unit: RTL and testbench
=================================

Name: ifetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the execute stage. Owns the PC register and requests instructions from instruction memory over a valid/ready-style handshake.
- Presents each instruction and its PC_plus_4 to decode/execute.
- Consumes the execute stage's Addr_Result and Zero, plus decoder control, to select the next PC (sequential, branch, jump, jump-register).
- Latches the jal link address.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 255, number of FETCH cycles without imem_rvalid before declaring fetch_err (range 1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request, high throughout FETCH.
- imem_addr  out  32  word address of the fetch, equal to pc.
- imem_rdata  in  32  instruction word, valid when imem_rvalid=1.
- imem_rvalid  in  1  memory response strobe.
- Instruction  out  32  latched instruction word.
- instr_valid  out  1  high while in EXEC; Instruction, pc and PC_plus_4 are stable.
- pc  out  32  current PC.
- PC_plus_4  out  32  pc+4, modulo 2^32.
- Addr_Result  in  32  branch target from execute.
- Zero  in  1  ALU zero flag from execute.
- Read_data_1  in  32  rs value, used for jr.
- Branch  in  1  beq.
- nBranch  in  1  bne.
- Jmp  in  1  j.
- Jal  in  1  jal.
- Jr  in  1  jr.
- stall  in  1  downstream hold request; keeps EXEC.
- link_addr  out  32  PC_plus_4 of the last retired jal.
- addr_err  out  1  sticky: a jr target was not word-aligned.
- fetch_err  out  1  sticky: fetch timeout occurred.

Behaviour:
- Reset (synchronous, any state):
  - pc=RESET_PC, Instruction=0, link_addr=0, addr_err=0, fetch_err=0, timeout counter=0, state=FETCH.
  - imem_req=0 and instr_valid=0 in the reset cycle.
  - An imem_rvalid arriving in the same cycle as reset is ignored.
- States: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - On imem_rvalid=1: Instruction<=imem_rdata, counter<=0, next state EXEC.
  - Otherwise counter increments; when counter reaches FETCH_TIMEOUT-1 with no rvalid, fetch_err<=1 and next state HALT.
- EXEC:
  - imem_req=0, instr_valid=1. Control inputs are combinational from decode/execute of the held Instruction.
  - stall=1: hold all state (pc, Instruction, outputs unchanged).
  - stall=0: pc<=next_pc, next state FETCH.
  - If Jal=1 and stall=0: link_addr<=PC_plus_4.
  - Minimum latency: 2 cycles per instruction with zero-wait-state memory (1 FETCH + 1 EXEC).
- HALT: imem_req=0, instr_valid=0, pc frozen; left only by reset.
- imem_rvalid outside FETCH is ignored.
- next_pc priority, highest first:
  1. Jr: {Read_data_1[31:2],2'b00}. If Read_data_1[1:0]!=0, addr_err<=1 (sticky).
  2. Jmp or Jal: {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
  3. Branch&Zero or nBranch&!Zero: {Addr_Result[31:2],2'b00}.
  4. Otherwise: PC_plus_4.
- Arithmetic: all 32-bit unsigned, wrap-around; pc=32'hFFFF_FFFC gives PC_plus_4=0.
- Simultaneous Branch and nBranch is illegal from decode; by the priority rule the result is still defined (taken to Addr_Result, since one of the two conditions always holds).
- pc[1:0] is always 00.

Test Plan:
- Reset then memory returns 32'h2008_0005 after 3 cycles → imem_req high 3 cycles with imem_addr=0, then instr_valid=1, Instruction=32'h2008_0005; next fetch at imem_addr=4.
- In EXEC at pc=32'h0000_0010: Branch=1, Zero=1, Addr_Result=32'h0000_0040 → next imem_addr=32'h0000_0040. Same with Zero=0 → 32'h0000_0014. nBranch=1, Zero=0 → 32'h0000_0040.
- jal: Instruction=32'h0C00_0100 at pc=32'h0040_0008 → next pc=32'h0000_0400, link_addr=32'h0040_000C.
- jr: Jr=1, Jmp=1, Read_data_1=32'h0000_0123 → next pc=32'h0000_0120 (Jr wins over Jmp), addr_err=1 and stays 1 after subsequent aligned jumps until reset.
- stall=1 for 4 cycles in EXEC → instr_valid, pc and Instruction unchanged, imem_req=0; PC advances the cycle after stall drops. Reset asserted during FETCH → pc=RESET_PC, imem_req=0 in the reset cycle.
- With FETCH_TIMEOUT=8, memory never responds → fetch_err=1 after 8 FETCH cycles, imem_req=0 thereafter; reset clears fetch_err. pc=32'hFFFF_FFFC sequential → PC_plus_4=0, next fetch at 0.

Source files
------------

// File: rtl/ifetch_pc_unit.sv
// ifetch_pc_unit: PC register and instruction fetch with a valid/ready memory handshake and next-PC selection
module ifetch_pc_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] PC_plus_4,
  input  logic [31:0] Addr_Result,
  input  logic        Zero,
  input  logic [31:0] Read_data_1,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jr,
  input  logic        stall,
  output logic [31:0] link_addr,
  output logic        addr_err,
  output logic        fetch_err
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  localparam logic [7:0] LIMIT = 8'(FETCH_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, link_q, link_d, next_pc;
  logic [7:0]  cnt_q, cnt_d;
  logic        addr_err_q, addr_err_d, fetch_err_q, fetch_err_d;
  logic        retire, fetch_ok, timeout, take_br;
  assign PC_plus_4   = pc_q + 32'd4;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign Instruction = instr_q;
  assign link_addr   = link_q;
  assign addr_err    = addr_err_q;
  assign fetch_err   = fetch_err_q;
  // gated by reset so the reset cycle itself never shows a request or a valid instruction
  assign imem_req    = (state_q == FETCH) && !reset;
  assign instr_valid = (state_q == EXEC) && !reset;
  always_comb begin
    take_br     = (Branch && Zero) || (nBranch && !Zero);
    next_pc     = Jr ? {Read_data_1[31:2], 2'b00} :
                  (Jmp || Jal) ? {PC_plus_4[31:28], instr_q[25:0], 2'b00} :
                  take_br ? {Addr_Result[31:2], 2'b00} : PC_plus_4;
    retire      = (state_q == EXEC) && !stall;
    fetch_ok    = (state_q == FETCH) && imem_rvalid;
    timeout     = (state_q == FETCH) && !imem_rvalid && (cnt_q == LIMIT);
    pc_d        = retire ? next_pc : pc_q;
    instr_d     = fetch_ok ? imem_rdata : instr_q;
    link_d      = (retire && Jal) ? PC_plus_4 : link_q;
    addr_err_d  = addr_err_q || (retire && Jr && (Read_data_1[1:0] != 2'b00));
    fetch_err_d = fetch_err_q || timeout;
    cnt_d       = (state_q != FETCH) ? cnt_q : imem_rvalid ? 8'd0 : cnt_q + 8'd1;
    state_d     = fetch_ok ? EXEC : timeout ? HALT : retire ? FETCH : state_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      link_q      <= '0;
      cnt_q       <= '0;
      addr_err_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      link_q      <= link_d;
      cnt_q       <= cnt_d;
      addr_err_q  <= addr_err_d;
      fetch_err_q <= fetch_err_d;
    end
  end
endmodule

// File: tb/tb_ifetch_pc_unit.sv
// tb_ifetch_pc_unit: directed scoreboard bench for ifetch_pc_unit
module tb_ifetch_pc_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req, imem_rvalid, instr_valid, Zero, Branch, nBranch, Jmp, Jal, Jr, stall;
  logic        addr_err, fetch_err;
  logic [31:0] imem_addr, imem_rdata, Instruction, pc, PC_plus_4, Addr_Result, Read_data_1, link_addr;
  logic [31:0] sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  always #5 clock = ~clock;
  ifetch_pc_unit #(.RESET_PC(32'h0), .FETCH_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .Instruction(Instruction),
    .instr_valid(instr_valid), .pc(pc), .PC_plus_4(PC_plus_4), .Addr_Result(Addr_Result),
    .Zero(Zero), .Read_data_1(Read_data_1), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp),
    .Jal(Jal), .Jr(Jr), .stall(stall), .link_addr(link_addr), .addr_err(addr_err),
    .fetch_err(fetch_err)
  );
  task automatic cyc();
    @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h with nothing expected", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask
  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb.push_back(exp);
    chk(tag, obs);
  endtask
  task automatic clr();
    {Branch, nBranch, Jmp, Jal, Jr, Zero, stall} = '0;
    Addr_Result = '0;
    Read_data_1 = '0;
  endtask
  // called in FETCH at a falling edge; returns at the falling edge of the EXEC cycle
  task automatic fetch(input logic [31:0] instr);
    imem_rvalid = 1'b1;
    imem_rdata = instr;
    cyc();
    imem_rvalid = 1'b0;
  endtask
  task automatic to_pc(input logic [31:0] a);
    fetch(32'h0);
    Jr = 1'b1;
    Read_data_1 = a;
    cyc();
    clr();
  endtask
  initial begin
    reset = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    clr();
    cyc();
    ck("rst_req", imem_req, 0);
    ck("rst_valid", instr_valid, 0);
    ck("rst_pc", pc, 32'h0);
    ck("rst_instr", Instruction, 32'h0);
    ck("rst_link", link_addr, 32'h0);
    ck("rst_aerr", addr_err, 0);
    ck("rst_ferr", fetch_err, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      ck("f1_req", imem_req, 1);
      ck("f1_addr", imem_addr, 32'h0);
      ck("f1_valid", instr_valid, 0);
    end
    fetch(32'h2008_0005);
    ck("f1_exec_valid", instr_valid, 1);
    ck("f1_exec_req", imem_req, 0);
    ck("f1_instr", Instruction, 32'h2008_0005);
    ck("f1_p4", PC_plus_4, 32'h4);
    sb.push_back(32'h4);
    cyc();
    chk("seq_addr", imem_addr);
    ck("seq_req", imem_req, 1);
    to_pc(32'h10);
    ck("jr_10", imem_addr, 32'h10);
    fetch(32'h1000_000F);
    Branch = 1'b1; Zero = 1'b1; Addr_Result = 32'h40;
    sb.push_back(32'h40);
    cyc(); clr();
    chk("beq_taken", imem_addr);
    to_pc(32'h10);
    fetch(32'h1000_000F);
    Branch = 1'b1; Zero = 1'b0; Addr_Result = 32'h40;
    sb.push_back(32'h14);
    cyc(); clr();
    chk("beq_not_taken", imem_addr);
    to_pc(32'h10);
    fetch(32'h1400_000F);
    nBranch = 1'b1; Zero = 1'b0; Addr_Result = 32'h40;
    sb.push_back(32'h40);
    cyc(); clr();
    chk("bne_taken", imem_addr);
    to_pc(32'h0040_0008);
    fetch(32'h0C00_0100);
    ck("jal_pc", pc, 32'h0040_0008);
    ck("jal_p4", PC_plus_4, 32'h0040_000C);
    Jal = 1'b1;
    sb.push_back(32'h400);
    sb.push_back(32'h0040_000C);
    cyc(); clr();
    chk("jal_target", imem_addr);
    chk("jal_link", link_addr);
    ck("aerr_before", addr_err, 0);
    fetch(32'h0800_0001);
    Jr = 1'b1; Jmp = 1'b1; Read_data_1 = 32'h123;
    sb.push_back(32'h120);
    cyc(); clr();
    chk("jr_over_jmp", imem_addr);
    ck("aerr_set", addr_err, 1);
    to_pc(32'h200);
    ck("aerr_sticky", addr_err, 1);
    ck("jr_200", imem_addr, 32'h200);
    fetch(32'hDEAD_BEEF);
    stall = 1'b1; Jal = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      ck("stall_valid", instr_valid, 1);
      ck("stall_pc", pc, 32'h200);
      ck("stall_instr", Instruction, 32'hDEAD_BEEF);
      ck("stall_req", imem_req, 0);
      ck("stall_link", link_addr, 32'h0040_000C);
    end
    clr();
    cyc();
    ck("unstall_addr", imem_addr, 32'h204);
    ck("unstall_valid", instr_valid, 0);
    reset = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1234_5678;
    #1;
    ck("rst_fetch_req", imem_req, 0);
    cyc();
    ck("rst_fetch_pc", pc, 32'h0);
    ck("rst_rvalid_ignored", Instruction, 32'h0);
    ck("rst_aerr_clr", addr_err, 0);
    reset = 1'b0;
    imem_rvalid = 1'b0;
    cyc();
    ck("post_rst_req", imem_req, 1);
    ck("post_rst_valid", instr_valid, 0);
    to_pc(32'hFFFF_FFFC);
    fetch(32'h0);
    ck("wrap_pc", pc, 32'hFFFF_FFFC);
    ck("wrap_p4", PC_plus_4, 32'h0);
    cyc();
    ck("wrap_addr", imem_addr, 32'h0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      ck("to_req", imem_req, 1);
      ck("to_ferr", fetch_err, 0);
    end
    cyc();
    ck("to_ferr_set", fetch_err, 1);
    ck("to_halt_req", imem_req, 0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    cyc();
    imem_rvalid = 1'b0;
    cyc();
    ck("halt_req", imem_req, 0);
    ck("halt_valid", instr_valid, 0);
    ck("halt_pc", pc, 32'h0);
    ck("halt_instr", Instruction, 32'h0);
    ck("halt_ferr", fetch_err, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ck("ferr_clr", fetch_err, 0);
    cyc();
    ck("restart_req", imem_req, 1);
    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
